fifo_ctrl: RTL and testbench



---
 rtl/fifo_ctrl.sv | 84 ++++++++
 tb/tb_fifo_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequential control stage of the 8-entry FIFO.
// Holds the operation state plus head/tail/data_count registers, reloads the
// pointers and count from the address-calculation block every cycle, and
// decodes the registered state/count into status and handshake flags.
module fifo_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] next_head,
  input  logic [ADDR_W-1:0] next_tail,
  input  logic [CNT_W-1:0]  next_data_count,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] head,
  output logic [ADDR_W-1:0] tail,
  output logic [CNT_W-1:0]  data_count,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  state_t state_q;
  state_t state_d;

  // State, pointers and count all load on the same edge; reset clears them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
    end else begin
      state_q    <= state_d;
      head       <= next_head;
      tail       <= next_tail;
      data_count <= next_data_count;
    end
  end

  // Next state judged against next_data_count so back-to-back requests see
  // the occupancy already updated by the operation in flight.
  always_comb begin
    state_d = INIT;
    case (state_q)
      INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR: begin
        if (wr_en && !rd_en) begin
          state_d = (next_data_count < FULL_CNT) ? WRITE : WR_ERROR;
        end else if (!wr_en && rd_en) begin
          state_d = (next_data_count != '0) ? READ : RD_ERROR;
        end else begin
          state_d = NO_OP;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign state  = state_q;
  assign full   = (data_count == FULL_CNT);
  assign empty  = (data_count == '0);
  assign wr_ack = (state_q == WRITE);
  assign wr_err = (state_q == WR_ERROR);
  assign rd_ack = (state_q == READ);
  assign rd_err = (state_q == RD_ERROR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: an abstract occupancy/pointer model predicts each
// cycle's state, pointers and flags; a monitor compares them after each edge.
module tb_fifo_ctrl;

  localparam logic [2:0] S_INIT = 3'b000, S_NOOP = 3'b001, S_WRITE = 3'b010,
                         S_WERR = 3'b011, S_READ = 3'b100, S_RERR  = 3'b101;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, rd_en;
  logic [2:0] next_head, next_tail;
  logic [3:0] next_data_count;
  logic [2:0] state, head, tail;
  logic [3:0] data_count;
  logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] st;
    int         h;
    int         t;
    int         c;
  } exp_t;
  exp_t sb[$];

  // Abstract FIFO model: count of stored items and wrapped pointer positions.
  int m_cnt, m_head, m_tail;

  fifo_ctrl #(.DEPTH(8), .ADDR_W(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .next_head(next_head), .next_tail(next_tail), .next_data_count(next_data_count),
    .state(state), .head(head), .tail(tail), .data_count(data_count),
    .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the address-calculation block the controller feeds.
  always_comb begin
    next_head       = head;
    next_tail       = tail;
    next_data_count = data_count;
    case (state)
      S_WRITE: begin
        next_tail       = tail + 3'd1;
        next_data_count = data_count + 4'd1;
      end
      S_READ: begin
        next_head       = head + 3'd1;
        next_data_count = data_count - 4'd1;
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request for the coming edge and queue the predicted outcome.
  task automatic cycle(input logic wr, input logic rd);
    exp_t e;
    wr_en = wr;
    rd_en = rd;
    e.h = m_head;
    e.t = m_tail;
    e.c = m_cnt;
    if (wr && !rd) begin
      if (m_cnt < 8) begin
        e.st = S_WRITE;
        m_tail = (m_tail + 1) % 8;
        m_cnt++;
      end else e.st = S_WERR;
    end else if (!wr && rd) begin
      if (m_cnt > 0) begin
        e.st = S_READ;
        m_head = (m_head + 1) % 8;
        m_cnt--;
      end else e.st = S_RERR;
    end else e.st = S_NOOP;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 32'(S_INIT));
    check({tag, "_ptrs"}, {26'd0, head, tail}, 32'd0);
    check({tag, "_count"}, 32'(data_count), 32'd0);
    check({tag, "_flags"}, {26'd0, full, empty, wr_ack, wr_err, rd_ack, rd_err}, 32'b010000);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic mid_cycle_reset();
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #2;
    check_reset_values("reset_held");
    reset = 1'b0;
    m_cnt = 0; m_head = 0; m_tail = 0;
    sb.delete();
  endtask

  // Monitor: compare the DUT against the oldest prediction just after each edge.
  initial begin
    exp_t e;
    logic [2:0] fl;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        fl = {(e.st == S_WRITE), (e.st == S_WERR), (e.st == S_READ)};
        check("state", 32'(state), 32'(e.st));
        check("head", 32'(head), 32'(e.h));
        check("tail", 32'(tail), 32'(e.t));
        check("count", 32'(data_count), 32'(e.c));
        check("flags", {26'd0, full, empty, wr_ack, wr_err, rd_ack, rd_err},
              {26'd0, (e.c == 8), (e.c == 0), fl, (e.st == S_RERR)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    m_cnt = 0; m_head = 0; m_tail = 0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset_state");
    reset = 1'b0;

    // Fill to 8, then one write too many.
    repeat (9) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("full_after_fill", {31'd0, full}, 32'd1);
    // Drain to 0, then one read too many.
    repeat (9) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("empty_after_drain", {31'd0, empty}, 32'd1);

    // Simultaneous requests at count 3 are ignored.
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);

    // Reach count 5, then reset mid-cycle.
    repeat (2) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("count_before_reset", 32'(data_count), 32'd5);
    mid_cycle_reset();

    // Wrap: write 6, read 6, write 4.
    repeat (6) cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    check("wrap_ptrs", {26'd0, head, tail}, {26'd0, 3'd6, 3'd2});
    check("wrap_count", 32'(data_count), 32'd4);

    // Back-to-back at the full boundary: 7 -> WRITE then immediate WR_ERROR.
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("b2b_write", 32'(state), 32'(S_WRITE));
    cycle(1'b1, 1'b0);
    check("b2b_wr_error", 32'(state), 32'(S_WERR));
    // And at the empty boundary: 1 -> READ then immediate RD_ERROR.
    repeat (7) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check("b2b_rd_error", 32'(state), 32'(S_RERR));

    // Random traffic, with one more asynchronous reset part-way through.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (i == 300) mid_cycle_reset();
      if (i < 150)      cycle(r < 6, r >= 8);
      else if (i < 300) cycle(r >= 8, r < 6);
      else              cycle(r[0], r[1]);
    end
    repeat (2) cycle(1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
